// File: rtl/adder_tree_accumulator_pkg.sv
// Shared constants for the lane-sum adder tree and its accumulator.
// Holds lane geometry, derived tree depth and the packed tree node layout.
package adder_tree_accumulator_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 16;
    localparam int OUT_W  = 13;
    localparam int IN_W   = ELEM_W * N_ELEM;
    localparam int LOG2_N = $clog2(N_ELEM);
    localparam int SUM_W  = ELEM_W + LOG2_N;

    // Bit offset of tree level lvl inside the flat node vector.
    // Level j holds N_ELEM>>j nodes of ELEM_W+j bits each.
    function automatic int node_off(input int lvl);
        int o;
        o = 0;
        for (int j = 0; j < lvl; j++)
            o += (N_ELEM >> j) * (ELEM_W + j);
        return o;
    endfunction

    localparam int TREE_BITS = node_off(LOG2_N + 1);

endpackage

// File: rtl/adder_tree.sv
// Combinational balanced reduction of N_ELEM unsigned lanes.
// Ports: in (packed lanes, lane k = in[8k+7:8k]), sum (SUM_W-bit total).
module adder_tree
    import adder_tree_accumulator_pkg::*;
(
    input  logic [IN_W-1:0]  in,
    output logic [SUM_W-1:0] sum
);

    // Every level is packed back to back; each level is one bit wider
    // than the one below it, so no pairwise add can overflow.
    logic [TREE_BITS-1:0] node;

    for (genvar l = 0; l <= LOG2_N; l++) begin : g_lvl
        localparam int W    = ELEM_W + l;
        localparam int BASE = node_off(l);
        localparam int NN   = N_ELEM >> l;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < NN; i++) begin : g_n
                assign node[BASE + W*i +: W] = in[ELEM_W*i +: ELEM_W];
            end
        end else begin : g_add
            localparam int PREV = node_off(l - 1);
            for (genvar i = 0; i < NN; i++) begin : g_n
                assign node[BASE + W*i +: W] =
                    W'(node[PREV + (W-1)*(2*i)   +: W-1]) +
                    W'(node[PREV + (W-1)*(2*i+1) +: W-1]);
            end
        end
    end

    assign sum = node[node_off(LOG2_N) +: SUM_W];

endmodule

// File: rtl/adder_tree_accumulator.sv
// Lane-sum reduction feeding a wrapping running-total register.
// Ports: clk, rst_n (sync, active-high), in_valid, in, partial_sum, result.
module adder_tree_accumulator
    import adder_tree_accumulator_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] partial_sum,
    output logic [OUT_W-1:0] result
);

    logic [SUM_W-1:0] tree_sum;

    adder_tree u_tree (
        .in  (in),
        .sum (tree_sum)
    );

    assign partial_sum = {{(OUT_W-SUM_W){1'b0}}, tree_sum};

    // Adding at OUT_W bits wraps modulo 2^OUT_W by construction.
    always_ff @(posedge clk) begin
        if (rst_n)
            result <= '0;
        else if (in_valid)
            result <= result + partial_sum;
    end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Self-checking bench for adder_tree_accumulator.
// Directed test-plan steps followed by randomized traffic vs a sum model.
module tb_adder_tree_accumulator;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in;
    logic [12:0]  partial_sum;
    logic [12:0]  result;

    int total = 0;
    int bad   = 0;
    int model = 0;

    adder_tree_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in          (in),
        .partial_sum (partial_sum),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lane_sum(input logic [127:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 16; k++)
            s += int'(w[8*k +: 8]);
        return s;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [127:0] one_lane(input int k, input logic [7:0] b);
        logic [127:0] w;
        w = '0;
        w[8*k +: 8] = b;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: drive, check the combinational
    // sum, clock once, advance the model, check the registered total.
    task automatic step(input logic r, input logic v,
                        input logic [127:0] w, input string tag);
        rst_n    = r;
        in_valid = v;
        in       = w;
        #1;
        chk({tag, ".psum"}, 32'(partial_sum), 32'(lane_sum(w)));
        @(posedge clk);
        if (r)
            model = 0;
        else if (v)
            model = (model + lane_sum(w)) % 8192;
        @(negedge clk);
        chk({tag, ".res"}, 32'(result), 32'(model));
    endtask

    initial begin
        logic [127:0] w;
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in       = fill(8'hFF);
        @(negedge clk);

        // Reset dominates valid
        step(1'b1, 1'b1, fill(8'hFF), "rst_ff");
        chk("rst_ff.const", 32'(result), 0);
        step(1'b1, 1'b1, fill(8'h00), "rst_00");
        chk("rst_00.psum0", 32'(partial_sum), 0);

        // Lane ordering
        for (int k = 0; k < 16; k++)
            w[8*k +: 8] = 8'(k);
        step(1'b0, 1'b1, w, "lanes");
        chk("lanes.120", 32'(result), 120);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, fill(8'($urandom)), "hold");
        chk("hold.120", 32'(result), 120);

        // Maximum and wrap from zero
        step(1'b1, 1'b0, '0, "rst_w");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, fill(8'hFF), "wrap");
        chk("wrap.4048", 32'(result), 4048);

        // 8191 + 1 -> 0
        step(1'b1, 1'b0, '0, "rst_x");
        step(1'b0, 1'b1, fill(8'hFF), "top1");
        step(1'b0, 1'b1, fill(8'hFF), "top2");
        step(1'b0, 1'b1, one_lane(3, 8'd31), "top3");
        chk("top.8191", 32'(result), 8191);
        step(1'b0, 1'b1, one_lane(0, 8'd1), "top4");
        chk("top.wrap0", 32'(result), 0);

        // Single-lane isolation
        step(1'b0, 1'b0, one_lane(15, 8'hFF), "lane15");
        chk("lane15.255", 32'(partial_sum), 255);
        step(1'b0, 1'b0, one_lane(0, 8'h01), "lane0");
        chk("lane0.1", 32'(partial_sum), 1);

        // Reset mid-operation
        step(1'b1, 1'b0, '0, "rst_m");
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, one_lane(i + 2, 8'd60) | one_lane(9, 8'd40), "acc");
        chk("acc.400", 32'(result), 400);
        step(1'b1, 1'b1, one_lane(5, 8'd100), "midrst");
        chk("midrst.0", 32'(result), 0);
        step(1'b0, 1'b1, one_lane(5, 8'd100), "resume");
        chk("resume.100", 32'(result), 100);

        // Gated valid
        step(1'b1, 1'b0, '0, "rst_g");
        for (int i = 0; i < 6; i++)
            step(1'b0, (i % 2) == 0, one_lane(7, 8'd50), "gate");
        chk("gate.150", 32'(result), 150);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++)
                w[32*k +: 32] = $urandom;
            if ($urandom_range(0, 3) == 0)
                w = fill(8'hFF);
            step($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                 w, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_tree_accumulator.md
# adder_tree_accumulator

Sums 16 unsigned 8-bit lanes packed into a 128-bit word through a combinational balanced adder tree. Accumulates the tree's 13-bit partial sum into a registered running total on every valid cycle. Sits in the datapath as a dot-product/reduction back end: the upstream block presents one 128-bit word per clock with a valid flag, and downstream logic reads the running total.

## Interface
- ELEM_W, 8: width of one unsigned lane.
- N_ELEM, 16: number of lanes. Must be a power of two; ELEM_W*N_ELEM = input width.
- OUT_W, 13: width of partial sum and accumulated result.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-high reset (the port keeps the codebase name rst_n; a value of 1 sampled at a rising edge resets).
- in_valid  input  1  qualifies `in` for accumulation this cycle.
- in  input  128  packed lanes; lane k = in[8k+7:8k], unsigned.
- partial_sum  output  13  combinational sum of the 16 lanes of `in`.
- result  output  13  registered running total.

## Operation
- Adder tree:
  - Purely combinational.
  - Four levels of pairwise adds: level 1 adds lane 2i and lane 2i+1 into 9-bit sums, then 10, 11 and 12 bits.
  - Each level widens by 1 bit, so no intermediate overflow.
  - The final 12-bit sum (max 16*255 = 4080) is zero-extended to OUT_W.
  - partial_sum never wraps.
- Accumulator:
  - At a rising edge with rst_n=1: result <= 0.
  - Else if in_valid=1: result <= (result + partial_sum) mod 2^13. Unsigned wrap, no saturation, no overflow flag.
  - Else: result holds.
- Reset dominates in_valid on the same edge.
- `in` is don't-care when in_valid=0. partial_sum still reflects `in` combinationally.
- No X-propagation requirement beyond the reset: after the first reset edge, result is defined.

## Timing
- partial_sum: zero-cycle latency from `in`.
- result: one-cycle latency. A word with in_valid=1 at edge N is included in result visible after edge N.
- Back-to-back valid words are accepted every cycle. There is no backpressure and no ready signal.
- Reset value: result = 0. partial_sum has no reset; it is a function of `in` only.
- Reset asserted mid-accumulation: result = 0 after that edge, and the word presented on that edge is discarded. Accumulation resumes on the first edge with rst_n=0 and in_valid=1.
- Wrap boundary: 8191 + 1 -> 0. 8160 + 4080 -> 4048.

## Structure
- Shared package holds:
  - ELEM_W, N_ELEM, OUT_W defaults.
  - Derived tree depth LOG2_N = 4.
  - Derived lane-sum width ELEM_W+LOG2_N = 12.
- Sub-module `adder_tree`: the combinational reduction, built as a generate loop over levels.
- The top `adder_tree_accumulator` instantiates `adder_tree` and holds the single result register plus the add/wrap logic.

## Test plan
- Reset:
  - Drive rst_n=1 for one edge with in_valid=1 and all lanes 0xFF -> result=0.
  - Same setup with lanes all 0x00 -> partial_sum=0.
- Lane ordering:
  - Lane k = k (k=0..15) -> partial_sum=120.
  - One valid cycle -> result=120.
  - in_valid=0 for 3 cycles -> result holds 120.
- Maximum and wrap:
  - All lanes 0xFF -> partial_sum=4080.
  - Valid for 3 consecutive cycles from 0 -> result sequence 4080, 8160, 4048.
- Single-lane isolation:
  - Only lane 15 = 0xFF, others 0 -> partial_sum=255.
  - Only lane 0 = 0x01 -> partial_sum=1.
- Reset mid-operation:
  - Accumulate 4 words of value-sum 100 -> result 400.
  - Assert rst_n=1 with in_valid=1 -> result=0.
  - Deassert, one valid word of 100 -> result=100.
- Gated valid:
  - Alternate in_valid 1/0 with partial_sum 50 for 6 cycles -> result 50, 50, 100, 100, 150, 150.
